// File: rtl/fwd_scoreboard_if.sv
// ID-stage issue/lookup bundle between the decode stage and the forwarding scoreboard.
// The master side drives the ID instruction; the slave side returns stall and forward selects.
interface fwd_scoreboard_if #(
    parameter int NUM_RD = 2,
    parameter int REG_AW = 5,
    parameter int SW     = 2,
    parameter int FW     = 2
);
    logic                     issue_valid;
    logic                     issue_regwr;
    logic [REG_AW-1:0]        issue_rd;
    logic [SW-1:0]            issue_lat;
    logic                     flush;
    logic [NUM_RD*REG_AW-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_used;
    logic                     stall;
    logic [NUM_RD*FW-1:0]     fwd_sel_ex;

    modport master (
        output issue_valid, issue_regwr, issue_rd, issue_lat, flush, rd_addr, rd_used,
        input  stall, fwd_sel_ex
    );

    modport slave (
        input  issue_valid, issue_regwr, issue_rd, issue_lat, flush, rd_addr, rd_used,
        output stall, fwd_sel_ex
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use stall unit: tracks in-flight register writes in a DEPTH-slot
// shadow pipeline and derives per-port forward selects plus a global stall for ID.
module fwd_scoreboard #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int SW     = $clog2(DEPTH),
    parameter int FW     = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fwd_scoreboard_if.slave     bus,
    output logic [15:0]         stall_cnt_o
);

    logic [DEPTH-1:0]     slot_v_q;
    logic [REG_AW-1:0]    slot_rd_q  [DEPTH];
    logic [SW-1:0]        slot_lat_q [DEPTH];
    logic [NUM_RD*FW-1:0] fwd_sel_q;
    logic [NUM_RD*FW-1:0] sel_d;
    logic [NUM_RD-1:0]    stall_req;
    logic [15:0]          stall_cnt_q;
    logic [SW-1:0]        lat_clamped;
    logic                 advance;

    assign lat_clamped = (int'(bus.issue_lat) > DEPTH - 1) ? SW'(DEPTH - 1) : bus.issue_lat;

    // Iterating oldest-to-youngest lets the youngest match overwrite older ones.
    always_comb begin
        logic              hit;
        int                idx;
        logic [REG_AW-1:0] addr;
        stall_req = '0;
        sel_d     = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            hit  = 1'b0;
            idx  = 0;
            addr = bus.rd_addr[p*REG_AW +: REG_AW];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (slot_v_q[i] && (slot_rd_q[i] == addr)) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
            if (bus.rd_used[p] && (addr != '0) && hit) begin
                if (int'(slot_lat_q[idx]) > idx) begin
                    stall_req[p] = 1'b1;
                end else begin
                    sel_d[p*FW +: FW] = FW'(idx + 1);
                end
            end
        end
    end

    assign bus.stall      = (|stall_req) & ~bus.flush;
    assign advance        = ~bus.stall & ~bus.flush;
    assign bus.fwd_sel_ex = fwd_sel_q;
    assign stall_cnt_o    = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_v_q    <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd_q[i]  <= '0;
                slot_lat_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                slot_v_q[i]   <= slot_v_q[i-1];
                slot_rd_q[i]  <= slot_rd_q[i-1];
                slot_lat_q[i] <= slot_lat_q[i-1];
            end
            slot_v_q[0]   <= advance & bus.issue_valid & bus.issue_regwr & (bus.issue_rd != '0);
            slot_rd_q[0]  <= bus.issue_rd;
            slot_lat_q[0] <= lat_clamped;
            fwd_sel_q     <= advance ? sel_d : '0;
            if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a DEPTH=3 instance for the forwarding cases and a
// DEPTH=64 instance that drives long back-to-back stalls into counter saturation.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NUM_RD(2), .REG_AW(5), .SW(2), .FW(2)) bus_a ();
    fwd_scoreboard_if #(.NUM_RD(2), .REG_AW(5), .SW(6), .FW(7)) bus_b ();
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    fwd_scoreboard #(.NUM_RD(2), .DEPTH(3), .REG_AW(5)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a.slave), .stall_cnt_o(cnt_a)
    );
    fwd_scoreboard #(.NUM_RD(2), .DEPTH(64), .REG_AW(5)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .stall_cnt_o(cnt_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the ID instruction of the DEPTH=3 instance, then lets combinational outputs settle.
    task automatic set_id(input logic v, input logic wr, input logic [4:0] rd, input logic [1:0] lat,
                          input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
        bus_a.issue_valid = v;
        bus_a.issue_regwr = wr;
        bus_a.issue_rd    = rd;
        bus_a.issue_lat   = lat;
        bus_a.rd_addr     = {a1, a0};
        bus_a.rd_used     = used;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n_stall;
        int exp_cnt;
        exp_cnt = 0;
        bus_a.flush = 1'b0;
        bus_b.flush = 1'b0;
        bus_b.issue_valid = 1'b0; bus_b.issue_regwr = 1'b0; bus_b.issue_rd = '0;
        bus_b.issue_lat = '0; bus_b.rd_addr = '0; bus_b.rd_used = '0;
        set_id(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
        tick(); tick();
        check("rst_stall", bus_a.stall, 0);
        check("rst_sel", bus_a.fwd_sel_ex, 0);
        check("rst_cnt", cnt_a, 0);
        rst = 1'b0;

        // ALU chain
        set_id(1, 1, 5'd5, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd5, 5'd0, 2'b01);
        check("alu_stall", bus_a.stall, 0);
        tick();
        check("alu_sel", bus_a.fwd_sel_ex, 4'b0001);
        idle(3);

        // Load-use on port 1
        set_id(1, 1, 5'd8, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd0, 5'd8, 2'b10);
        check("ld_stall", bus_a.stall, 1);
        tick(); exp_cnt++;
        check("ld_cnt", cnt_a, exp_cnt);
        check("ld_sel_bubble", bus_a.fwd_sel_ex, 0);
        check("ld_stall_clear", bus_a.stall, 0);
        tick();
        check("ld_sel", bus_a.fwd_sel_ex, 4'b1000);
        idle(3);

        // Youngest wins, both ready
        set_id(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd3, 5'd0, 2'b01);
        check("yw_stall", bus_a.stall, 0);
        tick();
        check("yw_sel", bus_a.fwd_sel_ex, 4'b0001);
        idle(3);

        // Youngest wins, younger not ready
        set_id(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 1, 5'd3, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd3, 5'd0, 2'b01);
        check("yw_ld_stall", bus_a.stall, 1);
        tick(); exp_cnt++;
        check("yw_ld_stall_clear", bus_a.stall, 0);
        tick();
        check("yw_ld_sel", bus_a.fwd_sel_ex, 4'b0010);
        idle(3);

        // Masking: port0 unused, port1 reads r0
        set_id(1, 1, 5'd9, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd9, 5'd0, 2'b10);
        check("mask_stall", bus_a.stall, 0);
        tick();
        check("mask_sel", bus_a.fwd_sel_ex, 0);
        idle(3);

        // Oldest slot forwards, then the value has retired
        set_id(1, 1, 5'd7, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        idle(2);
        set_id(1, 0, 5'd0, 2'd0, 5'd7, 5'd0, 2'b01);
        tick();
        check("old_sel", bus_a.fwd_sel_ex, 4'b0011);
        tick();
        check("retired_sel", bus_a.fwd_sel_ex, 0);
        idle(3);

        // Multi-port: ready ALU in slot1, load in slot0
        set_id(1, 1, 5'd4, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 1, 5'd6, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd4, 5'd6, 2'b11);
        check("mp_stall", bus_a.stall, 1);
        tick(); exp_cnt++;
        check("mp_sel_bubble", bus_a.fwd_sel_ex, 0);
        check("mp_stall_clear", bus_a.stall, 0);
        tick();
        check("mp_sel", bus_a.fwd_sel_ex, 4'b1011);
        idle(3);

        // Latency clamp: lat=3 behaves as 2
        set_id(1, 1, 5'd11, 2'd3, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd11, 5'd0, 2'b01);
        check("clamp_stall0", bus_a.stall, 1);
        tick(); exp_cnt++;
        check("clamp_stall1", bus_a.stall, 1);
        tick(); exp_cnt++;
        check("clamp_stall2", bus_a.stall, 0);
        tick();
        check("clamp_sel", bus_a.fwd_sel_ex, 4'b0011);
        idle(3);

        // Flush during load-use stall; the flushed ID instruction must not enter s[0]
        set_id(1, 1, 5'd8, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 1, 5'd10, 2'd0, 5'd8, 5'd0, 2'b01);
        check("fl_pre_stall", bus_a.stall, 1);
        bus_a.flush = 1'b1; #1;
        check("fl_stall", bus_a.stall, 0);
        tick();
        bus_a.flush = 1'b0;
        check("fl_cnt", cnt_a, exp_cnt);
        check("fl_sel", bus_a.fwd_sel_ex, 0);
        set_id(1, 0, 5'd0, 2'd0, 5'd10, 5'd8, 2'b11);
        check("fl_after_stall", bus_a.stall, 0);
        tick();
        check("fl_after_sel", bus_a.fwd_sel_ex, 4'b1000);
        idle(3);

        // Reset mid-stall
        set_id(1, 1, 5'd8, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd8, 5'd0, 2'b01);
        check("rs_pre_stall", bus_a.stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_stall", bus_a.stall, 0);
        check("rs_cnt", cnt_a, 0);
        tick();
        check("rs_sel", bus_a.fwd_sel_ex, 0);
        idle(1);

        // Saturation on the deep instance: every instruction writes and reads r1 at max latency
        bus_b.issue_valid = 1'b1; bus_b.issue_regwr = 1'b1; bus_b.issue_rd = 5'd1;
        bus_b.issue_lat = 6'd63; bus_b.rd_addr = {5'd0, 5'd1}; bus_b.rd_used = 2'b01;
        n_stall = 0;
        for (int c = 0; c < 80000 && n_stall < 70000; c++) begin
            @(negedge clk);
            if (bus_b.stall) n_stall++;
        end
        check("sat_stall_cycles", n_stall, 70000);
        @(negedge clk);
        check("sat_cnt", cnt_b, 32'h0000FFFF);
        rst = 1'b1;
        bus_b.issue_valid = 1'b0; bus_b.rd_used = 2'b00;
        tick();
        rst = 1'b0;
        check("sat_rst_cnt", cnt_b, 0);
        check("sat_rst_sel", bus_b.fwd_sel_ex, 0);
        bus_b.rd_used = 2'b01;
        #1;
        check("sat_rst_stall", bus_b.stall, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
